sif_xa_responder: RTL and testbench

//  Target end of the SIF XA bus: a 16-bit register file that services xa_wr_s/xa_rd_s accesses.

---
 rtl/sif_xa_responder_if.sv | 26 ++
 rtl/sif_xa_responder.sv | 132 +++++++++++++
 tb/tb_sif_xa_responder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/sif_xa_responder_if.sv
// SIF XA target bus bundle plus the forwarded WA write port and debug status.
// The master side drives XA accesses and wa_ready; the slave side is the responder.
// Pure wiring: no latency and no flow control of its own.
interface sif_xa_responder_if;
  logic [15:0] xa_addr;
  logic [15:0] xa_data_wr;
  logic        xa_wr_s;
  logic        xa_rd_s;
  logic [15:0] xa_data_rd;
  logic        wa_ready;
  logic [15:0] wa_addr;
  logic [15:0] wa_data_wr;
  logic        wa_wr_s;
  logic        fifo_ovf;
  logic [7:0]  err_cnt;

  modport master (
    output xa_addr, xa_data_wr, xa_wr_s, xa_rd_s, wa_ready,
    input  xa_data_rd, wa_addr, wa_data_wr, wa_wr_s, fifo_ovf, err_cnt
  );

  modport slave (
    input  xa_addr, xa_data_wr, xa_wr_s, xa_rd_s, wa_ready,
    output xa_data_rd, wa_addr, wa_data_wr, wa_wr_s, fifo_ovf, err_cnt
  );
endinterface

// File: rtl/sif_xa_responder.sv
// SIF XA register-file target; accepted writes are forwarded to the WA port through a FIFO.
// Latency: read data 1 cycle after the strobe; WA pulse 2 cycles after the write (wa_ready high).
// Backpressure: wa_ready stalls the WA drain; a push to a full FIFO without a pop is dropped (fifo_ovf).
// Optional: define SIF_WA_FILTER_EN to suppress writes that do not change the register value.
module sif_xa_responder #(
  parameter int          NUM_REGS   = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] BAD_DATA   = 16'hDEAD
) (
  input logic             clk,
  input logic             rst,
  sif_xa_responder_if.slave bus
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [15:0] regs [NUM_REGS];
  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [15:0] xa_data_rd_q;
  logic [15:0] wa_addr_q, wa_data_q;
  logic        wa_wr_q, ovf_q;
  logic [7:0]  err_q;

  logic          is_wr, is_rd, is_ill, in_range, redundant;
  logic [AW-1:0] idx;
  logic [15:0]   reg_cur;
  logic          full, empty, pop, push_req, push, drop, err_evt;

  // Exactly one access class is active per cycle; both strobes together is illegal.
  assign is_wr    = bus.xa_wr_s & ~bus.xa_rd_s;
  assign is_rd    = bus.xa_rd_s & ~bus.xa_wr_s;
  assign is_ill   = bus.xa_wr_s &  bus.xa_rd_s;
  assign in_range = (bus.xa_addr < 16'(NUM_REGS));
  assign idx      = bus.xa_addr[AW-1:0];
  assign reg_cur  = regs[idx];

`ifdef SIF_WA_FILTER_EN
  assign redundant = in_range && (reg_cur == bus.xa_data_wr);
`else
  assign redundant = 1'b0;
`endif

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = ~empty & bus.wa_ready;
  assign push_req = is_wr & in_range & ~redundant;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign err_evt  = is_ill | ((is_wr | is_rd) & ~in_range) | drop;

  // Register file: in-range writes update the addressed entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (push_req) begin
      regs[idx] <= bus.xa_data_wr;
    end
  end

  // FIFO payload storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.xa_addr, bus.xa_data_wr};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // WA drain: load the head and pulse the strobe whenever downstream is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      wa_addr_q <= '0;
      wa_data_q <= '0;
      wa_wr_q   <= 1'b0;
    end else begin
      wa_wr_q <= pop;
      if (pop) begin
        wa_addr_q <= fifo_mem[rd_ptr][31:16];
        wa_data_q <= fifo_mem[rd_ptr][15:0];
      end
    end
  end

  // Read data register; holds its value when no read or illegal access occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      xa_data_rd_q <= '0;
    end else if (is_ill) begin
      xa_data_rd_q <= BAD_DATA;
    end else if (is_rd) begin
      xa_data_rd_q <= in_range ? reg_cur : BAD_DATA;
    end
  end

  // Debug status: sticky overflow flag and a saturating error counter (+1 max per cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      err_q <= '0;
    end else begin
      if (drop) ovf_q <= 1'b1;
      if (err_evt && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign bus.xa_data_rd = xa_data_rd_q;
  assign bus.wa_addr    = wa_addr_q;
  assign bus.wa_data_wr = wa_data_q;
  assign bus.wa_wr_s    = wa_wr_q;
  assign bus.fifo_ovf   = ovf_q;
  assign bus.err_cnt    = err_q;

endmodule

// File: tb/tb_sif_xa_responder.sv
// Bench for sif_xa_responder: directed scenarios plus randomized traffic against a queue model.
// Inputs change 1 time unit after each rising edge; outputs are sampled at that same point.
// Honors SIF_WA_FILTER_EN in the model when the bundle is built with it.
module tb_sif_xa_responder;
  localparam int          NUM_REGS   = 16;
  localparam int          FIFO_DEPTH = 4;
  localparam logic [15:0] BAD        = 16'hDEAD;

  logic clk = 1'b0;
  logic rst;
  sif_xa_responder_if bus_if();

  sif_xa_responder #(.NUM_REGS(NUM_REGS), .FIFO_DEPTH(FIFO_DEPTH), .BAD_DATA(BAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;

  // reference model state
  logic [15:0] m_regs [NUM_REGS];
  logic [31:0] m_q [$];
  logic [15:0] m_rd, m_wa_addr, m_wa_data;
  logic        m_wa_vld, m_ovf;
  int          m_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Apply the architectural rules for one clock edge using the inputs held across it.
  task automatic step_model();
    int          sz;
    bit          pop, err, do_push;
    int          a;
    logic [31:0] e;
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
      m_q.delete();
      m_rd = '0; m_wa_addr = '0; m_wa_data = '0; m_wa_vld = 1'b0; m_ovf = 1'b0; m_err = 0;
      return;
    end
    sz  = m_q.size();
    pop = (sz > 0) && bus_if.wa_ready;
    err = 1'b0;
    a   = int'(bus_if.xa_addr);
    if (pop) begin
      e = m_q.pop_front();
      m_wa_vld = 1'b1; m_wa_addr = e[31:16]; m_wa_data = e[15:0];
    end else begin
      m_wa_vld = 1'b0;
    end
    if (bus_if.xa_wr_s && bus_if.xa_rd_s) begin
      err = 1'b1;
      m_rd = BAD;
    end else if (bus_if.xa_wr_s) begin
      if (a >= NUM_REGS) begin
        err = 1'b1;
      end else begin
        do_push = 1'b1;
`ifdef SIF_WA_FILTER_EN
        if (m_regs[a] == bus_if.xa_data_wr) do_push = 1'b0;
`endif
        m_regs[a] = bus_if.xa_data_wr;
        if (do_push) begin
          if (sz == FIFO_DEPTH && !pop) begin
            m_ovf = 1'b1;
            err = 1'b1;
          end else begin
            m_q.push_back({bus_if.xa_addr, bus_if.xa_data_wr});
          end
        end
      end
    end else if (bus_if.xa_rd_s) begin
      if (a >= NUM_REGS) begin
        err = 1'b1;
        m_rd = BAD;
      end else begin
        m_rd = m_regs[a];
      end
    end
    if (err && m_err < 255) m_err++;
  endtask

  task automatic compare_all();
    check("xa_data_rd", 32'(bus_if.xa_data_rd), 32'(m_rd));
    check("wa_wr_s",    32'(bus_if.wa_wr_s),    32'(m_wa_vld));
    check("wa_addr",    32'(bus_if.wa_addr),    32'(m_wa_addr));
    check("wa_data_wr", 32'(bus_if.wa_data_wr), 32'(m_wa_data));
    check("fifo_ovf",   32'(bus_if.fifo_ovf),   32'(m_ovf));
    check("err_cnt",    32'(bus_if.err_cnt),    32'(m_err));
  endtask

  task automatic cycle(input logic r, input logic w, input logic rd,
                       input logic [15:0] a, input logic [15:0] d, input logic rdy);
    rst               = r;
    bus_if.xa_wr_s    = w;
    bus_if.xa_rd_s    = rd;
    bus_if.xa_addr    = a;
    bus_if.xa_data_wr = d;
    bus_if.wa_ready   = rdy;
    @(posedge clk);
    step_model();
    #1;
    compare_all();
    if (bus_if.wa_wr_s === 1'b1) pulses++;
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 16'h0, 16'h0, 1'b0);
    cycle(1, 0, 0, 16'h0, 16'h0, 1'b0);
  endtask

  initial begin
    logic        r, w, rd, rdy;
    logic [15:0] a, d;
    int          k;

    // 1) reset state and a read of a cleared register
    do_reset();
    check("t1_rd0",  32'(bus_if.xa_data_rd), 32'h0);
    check("t1_wa0",  32'(bus_if.wa_wr_s),    32'h0);
    check("t1_ovf0", 32'(bus_if.fifo_ovf),   32'h0);
    check("t1_err0", 32'(bus_if.err_cnt),    32'h0);
    cycle(0, 0, 1, 16'd5, 16'h0, 1'b1);
    check("t1_rd5",  32'(bus_if.xa_data_rd), 32'h0);

    // 2) write then read back; WA pulse two edges after the write
    cycle(0, 1, 0, 16'd3, 16'hA5A5, 1'b1);
    check("t2_nowa", 32'(bus_if.wa_wr_s), 32'h0);
    cycle(0, 0, 1, 16'd3, 16'h0, 1'b1);
    check("t2_rd",   32'(bus_if.xa_data_rd), 32'hA5A5);
    check("t2_wa",   32'(bus_if.wa_wr_s),    32'h1);
    check("t2_wa_a", 32'(bus_if.wa_addr),    32'h3);
    check("t2_wa_d", 32'(bus_if.wa_data_wr), 32'hA5A5);

    // 3) overflow with WA stalled, then ordered drain of the four kept entries
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 16'(i), 16'h0100 + 16'(i), 1'b0);
    check("t3_ovf", 32'(bus_if.fifo_ovf), 32'h1);
    check("t3_err", 32'(bus_if.err_cnt),  32'h1);
    cycle(0, 0, 1, 16'd4, 16'h0, 1'b0);
    check("t3_reg4", 32'(bus_if.xa_data_rd), 32'h0104);
    pulses = 0;
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 16'h0, 16'h0, 1'b1);
    check("t3_pulses", 32'(pulses), 32'd4);
    check("t3_last_a", 32'(bus_if.wa_addr), 32'h3);

    // 4) illegal access, out-of-range write and read
    do_reset();
    pulses = 0;
    cycle(0, 1, 1, 16'd2, 16'hBEEF, 1'b1);
    cycle(0, 1, 0, 16'h0100, 16'h1111, 1'b1);
    cycle(0, 0, 1, 16'h0100, 16'h0, 1'b1);
    check("t4_err", 32'(bus_if.err_cnt),    32'd3);
    check("t4_bad", 32'(bus_if.xa_data_rd), 32'hDEAD);
    cycle(0, 0, 1, 16'd2, 16'h0, 1'b1);
    check("t4_reg2",   32'(bus_if.xa_data_rd), 32'h0);
    check("t4_pulses", 32'(pulses), 32'd0);

    // 5) full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 16'(8 + i), 16'h2000 + 16'(i), 1'b0);
    pulses = 0;
    cycle(0, 1, 0, 16'd12, 16'h2004, 1'b1);
    check("t5_ovf", 32'(bus_if.fifo_ovf), 32'h0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 16'h0, 16'h0, 1'b1);
    check("t5_pulses", 32'(pulses), 32'd5);
    check("t5_last_a", 32'(bus_if.wa_addr),    32'd12);
    check("t5_last_d", 32'(bus_if.wa_data_wr), 32'h2004);

    // 6) repeated identical write
    do_reset();
    pulses = 0;
    cycle(0, 1, 0, 16'd7, 16'h1234, 1'b1);
    cycle(0, 1, 0, 16'd7, 16'h1234, 1'b1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 16'h0, 16'h0, 1'b1);
`ifdef SIF_WA_FILTER_EN
    check("t6_pulses", 32'(pulses), 32'd1);
`else
    check("t6_pulses", 32'(pulses), 32'd2);
`endif

    // error counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) cycle(0, 1, 1, 16'd1, 16'h0, 1'b1);
    check("sat_err", 32'(bus_if.err_cnt), 32'hFF);

    // randomized traffic with occasional mid-operation reset
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 399) == 0);
      k  = $urandom_range(0, 9);
      w  = (k <= 3) || (k == 7);
      rd = (k >= 4 && k <= 7);
      a  = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, NUM_REGS - 1));
      d  = 16'($urandom_range(0, 3));
      rdy = ((i / 200) % 2 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 3);
      cycle(r, w, rd, a, d, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
